// File: rtl/adder_operand_sequencer_if.sv
// Operand stream, adder drive/return and result stream of the adder operand sequencer.
interface adder_operand_sequencer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             accum;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] add_cout;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready;

  // Sequencer side
  modport master (
    input  in_data, in_valid, accum, add_s, add_cout, res_ready,
    output in_ready, add_a, add_b, add_cin, res_sum, res_carry, res_ovf, res_valid
  );

  // Producer / adder / consumer side
  modport slave (
    output in_data, in_valid, accum, add_s, add_cout, res_ready,
    input  in_ready, add_a, add_b, add_cin, res_sum, res_carry, res_ovf, res_valid
  );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Pairs streamed operands into A/B for an external ripple-carry adder, waits a
// programmable settle time, then captures sum/carry/overflow onto a result stream.
// Accumulate mode feeds the previous sum and carry back in as A and carry-in.
module adder_operand_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic                       clk,
  input logic                       reset,
  adder_operand_sequencer_if.master bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   add_a_q;
  logic [WIDTH-1:0]   add_b_q;
  logic               add_cin_q;
  logic [WIDTH-1:0]   res_sum_q;
  logic               res_carry_q;
  logic               res_ovf_q;
  logic               res_valid_q;
  logic               in_ready_q;
  logic               have_prev;
  logic [WIDTH-1:0]   prev_sum;
  logic               prev_carry;

  // Only the top two carry bits matter; the rest of the vector is intentionally unused.
  logic unused_cout;
  assign unused_cout = ^bus.add_cout;

  // Operand pairing, settle countdown, result capture and accumulate bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      have_prev   <= 1'b0;
      prev_sum    <= '0;
      prev_carry  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.accum && have_prev) begin
              add_a_q    <= prev_sum;
              add_b_q    <= bus.in_data;
              add_cin_q  <= prev_carry;
              cnt        <= CNT_LOAD;
              in_ready_q <= 1'b0;
              state      <= S_SETTLE;
            end else begin
              add_a_q   <= bus.in_data;
              add_cin_q <= 1'b0;
              state     <= S_WAIT_B;
            end
          end
        end
        S_WAIT_B: begin
          if (bus.in_valid) begin
            add_b_q    <= bus.in_data;
            cnt        <= CNT_LOAD;
            in_ready_q <= 1'b0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_sum_q   <= bus.add_s;
            res_carry_q <= bus.add_cout[WIDTH-1];
            res_ovf_q   <= bus.add_cout[WIDTH-1] ^ bus.add_cout[WIDTH-2];
            res_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            prev_sum    <= res_sum_q;
            prev_carry  <= res_carry_q;
            have_prev   <= 1'b1;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered values onto the bus.
  assign bus.in_ready  = in_ready_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: two instances (SETTLE=1 and SETTLE=3) share
// one stimulus stream, each with its own ripple adder and transaction-level model.
module tb_adder_operand_sequencer;
  localparam int unsigned W  = 4;
  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         accum = 1'b0;
  logic         res_ready = 1'b1;
  logic [1:0]   glitch = 2'b00;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  adder_operand_sequencer_if #(.WIDTH(W)) if0 ();
  adder_operand_sequencer_if #(.WIDTH(W)) if1 ();

  adder_operand_sequencer #(.WIDTH(W), .SETTLE(S0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  adder_operand_sequencer #(.WIDTH(W), .SETTLE(S1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.master));

  // Ripple-carry adder returning {carry vector, sum}.
  function automatic logic [2*W-1:0] ripple(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic c;
    logic [W-1:0] s;
    logic [W-1:0] co;
    c = ci;
    for (int k = 0; k < int'(W); k++) begin
      s[k]  = a[k] ^ b[k] ^ c;
      c     = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
      co[k] = c;
    end
    return {co, s};
  endfunction

  logic [W-1:0] s0, s1;
  assign {if0.add_cout, s0} = ripple(if0.add_a, if0.add_b, if0.add_cin);
  assign {if1.add_cout, s1} = ripple(if1.add_a, if1.add_b, if1.add_cin);
  assign if0.add_s = glitch[0] ? ~s0 : s0;
  assign if1.add_s = glitch[1] ? ~s1 : s1;

  assign if0.in_data = in_data;   assign if1.in_data = in_data;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
  assign if0.accum = accum;       assign if1.accum = accum;
  assign if0.res_ready = res_ready; assign if1.res_ready = res_ready;

  logic [W-1:0] d_a[2], d_b[2], d_sum[2];
  logic         d_cin[2], d_carry[2], d_ovf[2], d_rv[2], d_ir[2];
  assign d_a[0] = if0.add_a;       assign d_a[1] = if1.add_a;
  assign d_b[0] = if0.add_b;       assign d_b[1] = if1.add_b;
  assign d_cin[0] = if0.add_cin;   assign d_cin[1] = if1.add_cin;
  assign d_sum[0] = if0.res_sum;   assign d_sum[1] = if1.res_sum;
  assign d_carry[0] = if0.res_carry; assign d_carry[1] = if1.res_carry;
  assign d_ovf[0] = if0.res_ovf;   assign d_ovf[1] = if1.res_ovf;
  assign d_rv[0] = if0.res_valid;  assign d_rv[1] = if1.res_valid;
  assign d_ir[0] = if0.in_ready;   assign d_ir[1] = if1.in_ready;

  // Transaction-level model: operand bookkeeping plus integer arithmetic.
  bit           m_busy[2], m_have_a[2], m_prev_v[2];
  int           m_vcyc[2];
  logic [W-1:0] m_a[2], m_b[2], m_prev_sum[2];
  logic         m_cin[2], m_prev_carry[2];
  logic [W-1:0] m_pend_sum[2], m_res_sum[2];
  logic         m_pend_carry[2], m_pend_ovf[2], m_res_carry[2], m_res_ovf[2];

  function automatic int settle_of(input int i);
    return (i == 0) ? int'(S0) : int'(S1);
  endfunction

  function automatic int as_signed(input logic [W-1:0] v);
    return (int'(v) >= (1 << (W - 1))) ? int'(v) - (1 << W) : int'(v);
  endfunction

  task automatic launch(input int i);
    int total, stotal;
    total  = int'(m_a[i]) + int'(m_b[i]) + int'(m_cin[i]);
    stotal = as_signed(m_a[i]) + as_signed(m_b[i]) + int'(m_cin[i]);
    m_pend_sum[i]   = W'(total);
    m_pend_carry[i] = (total >= (1 << W));
    m_pend_ovf[i]   = (stotal > (1 << (W - 1)) - 1) || (stotal < -(1 << (W - 1)));
    m_have_a[i]     = 1'b0;
    m_busy[i]       = 1'b1;
    m_vcyc[i]       = cyc + 1 + settle_of(i);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_have_a[i] = 1'b0; m_prev_v[i] = 1'b0;
        m_a[i] = '0; m_b[i] = '0; m_cin[i] = 1'b0;
        m_prev_sum[i] = '0; m_prev_carry[i] = 1'b0;
        m_res_sum[i] = '0; m_res_carry[i] = 1'b0; m_res_ovf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (in_valid) begin
            if (!m_have_a[i] && accum && m_prev_v[i]) begin
              m_a[i] = m_prev_sum[i]; m_b[i] = in_data; m_cin[i] = m_prev_carry[i];
              launch(i);
            end else if (!m_have_a[i]) begin
              m_a[i] = in_data; m_cin[i] = 1'b0; m_have_a[i] = 1'b1;
            end else begin
              m_b[i] = in_data;
              launch(i);
            end
          end
        end else if (cyc >= m_vcyc[i] && res_ready) begin
          m_prev_sum[i] = m_res_sum[i]; m_prev_carry[i] = m_res_carry[i];
          m_prev_v[i] = 1'b1; m_busy[i] = 1'b0;
        end
      end
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i] && cyc == m_vcyc[i]) begin
          m_res_sum[i] = m_pend_sum[i]; m_res_carry[i] = m_pend_carry[i]; m_res_ovf[i] = m_pend_ovf[i];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.in_ready", i), 32'(d_ir[i]), 32'(!m_busy[i]));
        chk($sformatf("u%0d.res_valid", i), 32'(d_rv[i]), 32'(m_busy[i] && cyc >= m_vcyc[i]));
        chk($sformatf("u%0d.add_a", i), 32'(d_a[i]), 32'(m_a[i]));
        chk($sformatf("u%0d.add_b", i), 32'(d_b[i]), 32'(m_b[i]));
        chk($sformatf("u%0d.add_cin", i), 32'(d_cin[i]), 32'(m_cin[i]));
        chk($sformatf("u%0d.res_sum", i), 32'(d_sum[i]), 32'(m_res_sum[i]));
        chk($sformatf("u%0d.res_carry", i), 32'(d_carry[i]), 32'(m_res_carry[i]));
        chk($sformatf("u%0d.res_ovf", i), 32'(d_ovf[i]), 32'(m_res_ovf[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_data = a; step();
    in_data = b; step();
    in_valid = 1'b0;
  endtask

  initial begin
    idle(2);
    cmp_en = 1'b1;
    chk("rst_add_a", 32'(d_a[0]), 0);
    chk("rst_res_valid", 32'(d_rv[0]), 0);
    chk("rst_in_ready", 32'(d_ir[0]), 1);
    reset = 1'b0;

    // Basic add 3+5
    send_pair(4'd3, 4'd5);
    chk("basic_add_a", 32'(d_a[0]), 3);
    chk("basic_add_b", 32'(d_b[0]), 5);
    chk("basic_add_cin", 32'(d_cin[0]), 0);
    chk("basic_rv_early", 32'(d_rv[0]), 0);
    step();
    chk("basic_rv", 32'(d_rv[0]), 1);
    chk("basic_sum", 32'(d_sum[0]), 8);
    chk("basic_carry", 32'(d_carry[0]), 0);
    chk("basic_ovf", 32'(d_ovf[0]), 1);
    step();
    chk("basic_rv_drop", 32'(d_rv[0]), 0);
    chk("basic_ready_back", 32'(d_ir[0]), 1);
    idle(4);

    // Carry out, then a plain add
    send_pair(4'd9, 4'd8); step();
    chk("carry_sum", 32'(d_sum[0]), 1);
    chk("carry_carry", 32'(d_carry[0]), 1);
    chk("carry_ovf", 32'(d_ovf[0]), 1);
    idle(4);
    send_pair(4'd2, 4'd3); step();
    chk("plain_sum", 32'(d_sum[0]), 5);
    chk("plain_carry", 32'(d_carry[0]), 0);
    chk("plain_ovf", 32'(d_ovf[0]), 0);
    idle(4);

    // Chaining F+1 then accumulate 2
    send_pair(4'hF, 4'h1); step();
    chk("chain0_sum", 32'(d_sum[0]), 0);
    chk("chain0_carry", 32'(d_carry[0]), 1);
    idle(4);
    accum = 1'b1; in_data = 4'd2; in_valid = 1'b1; step();
    in_valid = 1'b0; accum = 1'b0;
    chk("chain_add_a", 32'(d_a[0]), 0);
    chk("chain_add_b", 32'(d_b[0]), 2);
    chk("chain_add_cin", 32'(d_cin[0]), 1);
    chk("chain_single_op", 32'(d_ir[0]), 0);
    step();
    chk("chain_rv", 32'(d_rv[0]), 1);
    chk("chain_sum", 32'(d_sum[0]), 3);
    chk("chain_carry", 32'(d_carry[0]), 0);
    idle(4);

    // Backpressure with a pending operand on the input
    res_ready = 1'b0;
    send_pair(4'd1, 4'd2); step();
    in_valid = 1'b1; in_data = 4'd7;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rv", 32'(d_rv[0]), 1);
      chk("bp_sum", 32'(d_sum[0]), 3);
      chk("bp_in_ready", 32'(d_ir[0]), 0);
      step();
    end
    in_valid = 1'b0; res_ready = 1'b1; step();
    chk("bp_release_ready", 32'(d_ir[0]), 1);
    chk("bp_release_rv", 32'(d_rv[0]), 0);
    idle(2);
    send_pair(4'd4, 4'd4); step();
    chk("bp_no_consume_sum", 32'(d_sum[0]), 8);
    idle(4);

    // Reset while waiting for B
    in_valid = 1'b1; in_data = 4'd5; step();
    in_valid = 1'b0;
    chk("mid_add_a", 32'(d_a[0]), 5);
    reset = 1'b1; #1;
    chk("mid_rst_add_a0", 32'(d_a[0]), 0);
    chk("mid_rst_add_a1", 32'(d_a[1]), 0);
    chk("mid_rst_add_b", 32'(d_b[0]), 0);
    chk("mid_rst_sum", 32'(d_sum[0]), 0);
    chk("mid_rst_ovf", 32'(d_ovf[0]), 0);
    step();
    reset = 1'b0;
    accum = 1'b1; in_data = 4'd4; in_valid = 1'b1; step();
    in_valid = 1'b0; accum = 1'b0;
    chk("post_rst_wait_b", 32'(d_ir[0]), 1);
    chk("post_rst_add_a", 32'(d_a[0]), 4);
    in_valid = 1'b1; in_data = 4'd3; step();
    in_valid = 1'b0; step();
    chk("post_rst_sum", 32'(d_sum[0]), 7);
    chk("post_rst_rv", 32'(d_rv[0]), 1);
    idle(4);

    // SETTLE=3 instance ignores adder output until the final settle cycle
    in_valid = 1'b1; in_data = 4'd6; step();
    in_data = 4'd1; step();
    in_valid = 1'b0; glitch[1] = 1'b1;
    step(); step();
    glitch[1] = 1'b0;
    chk("s3_rv_c5", 32'(d_rv[1]), 0);
    step();
    chk("s3_rv_c6", 32'(d_rv[1]), 1);
    chk("s3_sum", 32'(d_sum[1]), 7);
    chk("s3_carry", 32'(d_carry[1]), 0);
    idle(3);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
